univ_shift_reg: RTL and testbench

//  Parametrised universal shift register; successor to the fixed serial-in/serial-out shifter.

---
 rtl/usr_pkg.sv | 7 +
 rtl/usr_fill_cnt.sv | 45 ++++
 rtl/univ_shift_reg.sv | 98 +++++++++
 tb/tb_univ_shift_reg.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register.
package usr_pkg;
  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;
  localparam logic [1:0] USR_SHL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;
endpackage

// File: rtl/usr_fill_cnt.sv
// Saturating fill counter for univ_shift_reg: counts serially shifted bits,
// jumps to WIDTH on load, and pulses done on the WIDTH-1 -> WIDTH shift.
module usr_fill_cnt
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  input  logic             load,
  output logic [CNT_W-1:0] fill_cnt,
  output logic             full,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_full;

  assign w_full = (r_cnt == CNT_W'(WIDTH));

  always_ff @(posedge clock) begin
    if (clear) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (load) begin
        r_cnt <= CNT_W'(WIDTH);
      end else if (inc && !w_full) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      // A load or an already-full shift never reaches this edge from WIDTH-1.
      r_done <= inc && (r_cnt == CNT_W'(WIDTH - 1));
    end
  end

  assign fill_cnt = r_cnt;
  assign full     = w_full;
  assign done     = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift-right / shift-left / parallel load.
// Define USR_ROTATE_EN to let rot=1 turn SHR/SHL into rotates.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic             rot,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] fill_cnt,
  output logic             full,
  output logic             done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_inc;
  logic             w_load;
  logic             w_rot;

`ifdef USR_ROTATE_EN
  assign w_rot = rot;
`else
  logic w_unused_rot;
  assign w_unused_rot = rot;
  assign w_rot        = 1'b0;
`endif

  always_comb begin
    w_q_nxt = r_q;
    w_inc   = 1'b0;
    w_load  = 1'b0;
    if (en) begin
      case (mode)
        USR_SHR: begin
          if (w_rot) begin
            w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
          end else begin
            w_q_nxt = {sin, r_q[WIDTH-1:1]};
            w_inc   = 1'b1;
          end
        end
        USR_SHL: begin
          if (w_rot) begin
            w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          end else begin
            w_q_nxt = {r_q[WIDTH-2:0], sin};
            w_inc   = 1'b1;
          end
        end
        USR_LOAD: begin
          w_q_nxt = pdata;
          w_load  = 1'b1;
        end
        default: begin
          w_q_nxt = r_q;
        end
      endcase
    end else begin
      w_q_nxt = r_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  usr_fill_cnt #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_fill_cnt (
    .clock    (clock),
    .clear    (reset),
    .inc      (w_inc),
    .load     (w_load),
    .fill_cnt (fill_cnt),
    .full     (full),
    .done     (done)
  );

  assign q      = r_q;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8) against a behavioural model.
module tb_univ_shift_reg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset, en, sin, rot;
  logic [1:0]       mode;
  logic [WIDTH-1:0] pdata;
  logic [WIDTH-1:0] q;
  logic             sout_r, sout_l, full, done;
  logic [CNT_W-1:0] fill_cnt;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  bit model_on = 1'b0;

  logic [WIDTH-1:0] m_q;
  int               m_fill;
  bit               m_done;

  always #5 clock = ~clock;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .sin(sin), .rot(rot),
    .pdata(pdata), .q(q), .sout_r(sout_r), .sout_l(sout_l),
    .fill_cnt(fill_cnt), .full(full), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model at the edge, return at negedge.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic s, input logic ro, input logic [WIDTH-1:0] pd);
    int prev;
    reset = r; en = e; mode = m; sin = s; rot = ro; pdata = pd;
    @(posedge clock);
    prev = m_fill;
    if (r) begin
      m_q = '0; m_fill = 0; m_done = 1'b0;
    end else if (!e || m == 2'd0) begin
      m_done = 1'b0;
    end else if (m == 2'd3) begin
      m_q = pd; m_fill = WIDTH; m_done = 1'b0;
    end else if (ROT && ro) begin
      if (m == 2'd1) m_q = (m_q >> 1) | (WIDTH'(m_q[0]) << (WIDTH - 1));
      else           m_q = (m_q << 1) | WIDTH'(m_q[WIDTH-1]);
      m_done = 1'b0;
    end else begin
      if (m == 2'd1) m_q = (m_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
      else           m_q = (m_q << 1) | WIDTH'(s);
      m_fill = (prev + 1 > WIDTH) ? WIDTH : prev + 1;
      m_done = (prev == WIDTH - 1);
    end
    model_on = 1'b1;
    @(negedge clock);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (model_on) begin
      chk("q", 32'(q), 32'(m_q));
      chk("fill_cnt", 32'(fill_cnt), 32'(m_fill));
      chk("full", 32'(full), 32'(m_fill == WIDTH));
      chk("done", 32'(done), 32'(m_done));
      chk("sout_r", 32'(sout_r), 32'(m_q[0]));
      chk("sout_l", 32'(sout_l), 32'(m_q[WIDTH-1]));
      if (done) done_seen++;
    end
  end

  initial begin
    logic [7:0] pat;
    m_q = '0; m_fill = 0; m_done = 1'b0;
    pat = 8'b0100_1101;

    // 1: reset overrides LOAD
    step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'hFF);
    step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'hFF);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_fill", 32'(fill_cnt), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // 2: SHR fill with sin 1,0,1,1,0,0,1,0
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 2'd1, pat[i], 1'b0, 8'h00);
      chk("t2_fill", 32'(fill_cnt), 32'(i + 1));
      chk("t2_done", 32'(done), 32'(i == 7));
    end
    chk("t2_q", 32'(q), 32'h4D);
    chk("t2_full", 32'(full), 32'd1);
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    chk("t2_done_drop", 32'(done), 32'd0);
    chk("t2_full_hold", 32'(full), 32'd1);

    // 3: LOAD then SHL x3
    done_seen = 0;
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'hA5);
    chk("t3_load_q", 32'(q), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00);
      chk("t3_fill", 32'(fill_cnt), 32'd8);
    end
    chk("t3_q", 32'(q), 32'h28);
    chk("t3_sout_l", 32'(sout_l), 32'd0);
    chk("t3_no_done", 32'(done_seen), 32'd0);

    // 4: SHR x4, en=0 x3, SHL x4
    step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    done_seen = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00);
      chk("t4_frozen", 32'(fill_cnt), 32'd4);
      chk("t4_frozen_q", 32'(q), 32'hF0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00);
    chk("t4_fill", 32'(fill_cnt), 32'd8);
    chk("t4_done_now", 32'(done), 32'd1);
    chk("t4_q", 32'(q), 32'h00);
    step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00);
    chk("t4_pulses", 32'(done_seen), 32'd1);

    // 5: reset mid-fill, then a full refill
    step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
    chk("t5_mid_fill", 32'(fill_cnt), 32'd5);
    step(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
    chk("t5_rst_q", 32'(q), 32'h00);
    chk("t5_rst_fill", 32'(fill_cnt), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00);
    chk("t5_pulses", 32'(done_seen), 32'd1);
    chk("t5_q", 32'(q), 32'hFF);

    // 6: rotate requests (shifts with sin=0 when rotation is not built in)
    done_seen = 0;
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'h81);
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 8'h00);
    chk("t6_shr", 32'(q), ROT ? 32'hC0 : 32'h40);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 8'h00);
    chk("t6_shl", 32'(q), ROT ? 32'h81 : 32'h80);
    chk("t6_fill", 32'(fill_cnt), 32'd8);
    chk("t6_no_done", 32'(done_seen), 32'd0);

    model_on = 1'b0;
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
